// File: rtl/peaks_frame_scheduler_if.sv
// Signal bundle between the frame scheduler, the FFT/peaks datapath and the host.
// With PEAKS_FRAME_SCHEDULER_AMPL_EN defined the record also carries the peak amplitudes.
interface peaks_frame_scheduler_if #(
    parameter int PEAKS      = 6,
    parameter int FREQ_WIDTH = 9,
    parameter int AMPL_WIDTH = 8,
    parameter int TIME_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
);
`ifdef PEAKS_FRAME_SCHEDULER_AMPL_EN
    localparam int REC_W = PEAKS*AMPL_WIDTH + TIME_WIDTH + PEAKS*FREQ_WIDTH;
`else
    localparam int REC_W = TIME_WIDTH + PEAKS*FREQ_WIDTH;
`endif
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                        frame_req;
    logic                        frame_ack;
    logic                        peaks_valid;
    logic [TIME_WIDTH-1:0]       peaks_counter;
    logic [PEAKS*FREQ_WIDTH-1:0] peaks_freqs;
    logic [PEAKS*AMPL_WIDTH-1:0] peaks_ampls;
    logic                        rd_en;
    logic [REC_W-1:0]            rd_data;
    logic                        rd_empty;
    logic [LVL_W-1:0]            fifo_level;
    logic [15:0]                 drop_count;
    logic                        timeout_err;
    logic                        clear_err;
    logic                        busy;

    // Scheduler side
    modport slave (
        input  frame_req, peaks_counter, peaks_freqs, peaks_ampls, rd_en, clear_err,
        output frame_ack, peaks_valid, rd_data, rd_empty, fifo_level, drop_count,
               timeout_err, busy
    );

    // Datapath / host side
    modport master (
        output frame_req, peaks_counter, peaks_freqs, peaks_ampls, rd_en, clear_err,
        input  frame_ack, peaks_valid, rd_data, rd_empty, fifo_level, drop_count,
               timeout_err, busy
    );
endinterface

// File: rtl/peaks_frame_scheduler.sv
// Peaks frame scheduler: rate-limits FFT frames into the peaks block, waits for
// each completed peak set and queues a fingerprint record for the host.
// Optional: PEAKS_FRAME_SCHEDULER_AMPL_EN adds the peak amplitudes to each record.
module peaks_frame_scheduler #(
    parameter int PEAKS      = 6,
    parameter int FREQ_WIDTH = 9,
    parameter int AMPL_WIDTH = 8,
    parameter int TIME_WIDTH = 16,
    parameter int MIN_GAP    = 272,
    parameter int TIMEOUT    = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input logic                      clk,
    input logic                      reset,
    peaks_frame_scheduler_if.slave   bus_if
);
    localparam int FW    = PEAKS*FREQ_WIDTH;
`ifdef PEAKS_FRAME_SCHEDULER_AMPL_EN
    localparam int AW    = PEAKS*AMPL_WIDTH;
    localparam int REC_W = AW + TIME_WIDTH + FW;
`else
    localparam int REC_W = TIME_WIDTH + FW;
`endif
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = 16;

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

    state_t                state_q, state_d;
    logic [TIME_WIDTH-1:0] cnt_s1_q, cnt_s2_q;
    logic [FW-1:0]         frq_s1_q, frq_s2_q;
    logic [TIME_WIDTH-1:0] last_cnt_q, last_cnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic                  valid_q, valid_d;
    logic                  ack_q, ack_d;
    logic                  drop, push, pop, tmo;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [REC_W-1:0]      mem_q [FIFO_DEPTH];
    logic [REC_W-1:0]      rec_in;
    logic [15:0]           drop_q;
    logic                  terr_q;
    logic                  fifo_full, gap_ok;

`ifdef PEAKS_FRAME_SCHEDULER_AMPL_EN
    logic [AW-1:0]         amp_s1_q, amp_s2_q;
    assign rec_in = {amp_s2_q, cnt_s2_q, frq_s2_q};
`else
    logic unused_ampl;
    assign unused_ampl = ^bus_if.peaks_ampls;
    assign rec_in = {cnt_s2_q, frq_s2_q};
`endif

    assign fifo_full = (level_q == LVL_W'(FIFO_DEPTH));
    assign gap_ok    = (gap_q == '0);
    assign pop       = bus_if.rd_en && (level_q != '0);

    // Two-stage capture of the peaks outputs, which run on an unrelated clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_s1_q <= '0;
            cnt_s2_q <= '0;
            frq_s1_q <= '0;
            frq_s2_q <= '0;
`ifdef PEAKS_FRAME_SCHEDULER_AMPL_EN
            amp_s1_q <= '0;
            amp_s2_q <= '0;
`endif
        end else begin
            cnt_s1_q <= bus_if.peaks_counter;
            cnt_s2_q <= cnt_s1_q;
            frq_s1_q <= bus_if.peaks_freqs;
            frq_s2_q <= frq_s1_q;
`ifdef PEAKS_FRAME_SCHEDULER_AMPL_EN
            amp_s1_q <= bus_if.peaks_ampls;
            amp_s2_q <= amp_s1_q;
`endif
        end
    end

    // Scheduler state and its registered strobes / counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_cnt_q <= '0;
            gap_q      <= '0;
            to_q       <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_cnt_q <= last_cnt_d;
            gap_q      <= gap_d;
            to_q       <= to_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
        end
    end

    // Next state: issue/drop in IDLE, watch for a counter change in WAIT, push in CAPTURE.
    // last_cnt follows the synced counter outside WAIT so stale changes never trigger a push.
    // A request is ignored in the cycle its ack is out, since the requester drops it then.
    always_comb begin
        state_d    = state_q;
        last_cnt_d = cnt_s2_q;
        gap_d      = gap_ok ? gap_q : gap_q - GAP_W'(1);
        to_d       = '0;
        valid_d    = 1'b0;
        ack_d      = 1'b0;
        drop       = 1'b0;
        push       = 1'b0;
        tmo        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_if.frame_req && !ack_q) begin
                    if (fifo_full) begin
                        ack_d = 1'b1;
                        drop  = 1'b1;
                    end else if (gap_ok) begin
                        ack_d   = 1'b1;
                        valid_d = 1'b1;
                        gap_d   = GAP_W'(MIN_GAP - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                last_cnt_d = last_cnt_q;
                if (cnt_s2_q != last_cnt_q) begin
                    last_cnt_d = cnt_s2_q;
                    state_d    = CAPTURE;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            CAPTURE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + LVL_W'(1);
        else if (pop && !push)
            level_d = level_q - LVL_W'(1);
    end

    // FIFO pointers and level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            level_q <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Record storage; a slot was reserved at issue time, so a push always has room
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rec_in;
    end

    // Error reporting: clear_err beats any same-cycle drop or timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
            terr_q <= 1'b0;
        end else if (bus_if.clear_err) begin
            drop_q <= '0;
            terr_q <= 1'b0;
        end else begin
            if (drop && drop_q != '1) drop_q <= drop_q + 16'd1;
            if (tmo) terr_q <= 1'b1;
        end
    end

    assign bus_if.frame_ack   = ack_q;
    assign bus_if.peaks_valid = valid_q;
    assign bus_if.rd_data     = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign bus_if.rd_empty    = (level_q == '0);
    assign bus_if.fifo_level  = level_q;
    assign bus_if.drop_count  = drop_q;
    assign bus_if.timeout_err = terr_q;
    assign bus_if.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_peaks_frame_scheduler.sv
// Self-checking bench for peaks_frame_scheduler: directed table, hand sequences
// for the multi-cycle corners and a randomized run against a record-queue model.
module tb_peaks_frame_scheduler;
    localparam int PEAKS = 6, FREQ_WIDTH = 9, AMPL_WIDTH = 8, TIME_WIDTH = 16;
    localparam int MIN_GAP = 272, TIMEOUT = 1024, FIFO_DEPTH = 4;
    localparam int FW = PEAKS*FREQ_WIDTH;
    localparam int AW = PEAKS*AMPL_WIDTH;
`ifdef PEAKS_FRAME_SCHEDULER_AMPL_EN
    localparam int REC_W = AW + TIME_WIDTH + FW;
`else
    localparam int REC_W = TIME_WIDTH + FW;
`endif
    typedef logic [REC_W-1:0] rec_t;

    typedef struct {
        bit req; bit rd; bit chg;
        bit e_vld; bit e_ack; bit e_busy; int e_lvl; bit e_empty;
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    rec_t exp_q[$];
    logic [AW-1:0] amp = '0;
    logic [FW-1:0] F1, F2, F3, F4;
    row_t tbl[9];
    bit   got;
    int   p1, p2, extra, ackmis, n, drops, last_p, pend, prev_lvl;
    logic [15:0] cur_cnt;
    logic [FW-1:0] rf;
    bit   rd;

    peaks_frame_scheduler_if #(.PEAKS(PEAKS), .FREQ_WIDTH(FREQ_WIDTH), .AMPL_WIDTH(AMPL_WIDTH),
        .TIME_WIDTH(TIME_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    peaks_frame_scheduler #(.PEAKS(PEAKS), .FREQ_WIDTH(FREQ_WIDTH), .AMPL_WIDTH(AMPL_WIDTH),
        .TIME_WIDTH(TIME_WIDTH), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT),
        .FIFO_DEPTH(FIFO_DEPTH)) dut (.clk(clk), .reset(reset), .bus_if(bus));

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mkf(input int b0, input int b1, input int b2,
                                          input int b3, input int b4, input int b5);
        return {FREQ_WIDTH'(b5), FREQ_WIDTH'(b4), FREQ_WIDTH'(b3),
                FREQ_WIDTH'(b2), FREQ_WIDTH'(b1), FREQ_WIDTH'(b0)};
    endfunction

    function automatic rec_t mkrec(input logic [15:0] c, input logic [FW-1:0] f);
`ifdef PEAKS_FRAME_SCHEDULER_AMPL_EN
        return {amp, c, f};
`else
        return {c, f};
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_peaks(input logic [15:0] c, input logic [FW-1:0] f);
        amp = AW'({$urandom(), $urandom()});
        bus.peaks_counter = c;
        bus.peaks_freqs   = f;
        bus.peaks_ampls   = amp;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.frame_req = 1'b0;
        bus.rd_en = 1'b0;
        bus.clear_err = 1'b0;
        set_peaks(16'd0, '0);
        repeat (3) tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Raise frame_req until acknowledged; got = whether the ack came with a pulse
    task automatic request(output bit g);
        bit done;
        done = 0;
        g = 0;
        bus.frame_req = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick();
            if (bus.frame_ack) begin
                done = 1;
                g = bus.peaks_valid;
            end
        end
        bus.frame_req = 1'b0;
        if (!done) chk("req_ack_timeout", 128'(0), 128'(1));
    endtask

    // One frame: issue, step the counter, check 4-clock capture latency, optional pop in CAPTURE
    task automatic do_frame(input logic [15:0] c, input logic [FW-1:0] f, input bit pop_cap,
                            output bit g);
        rec_t r;
        int   lvl;
        request(g);
        if (g) begin
            tick();
            set_peaks(c, f);
            r = mkrec(c, f);
            repeat (3) tick();
            chk("capture_busy", 128'(bus.busy), 128'(1));
            lvl = int'(bus.fifo_level);
            if (pop_cap) begin
                if (exp_q.size() == 0) chk("cap_pop_model_empty", 128'(0), 128'(1));
                else chk("cap_pop_data", 128'(bus.rd_data), 128'(exp_q.pop_front()));
                bus.rd_en = 1'b1;
            end
            tick();
            bus.rd_en = 1'b0;
            exp_q.push_back(r);
            chk("after_push_busy", 128'(bus.busy), 128'(0));
            chk("after_push_level", 128'(bus.fifo_level), 128'(pop_cap ? lvl : lvl + 1));
            if (lvl == 0 && !pop_cap) chk("push_head_data", 128'(bus.rd_data), 128'(r));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && !bus.rd_empty; i++) begin
            if (exp_q.size() == 0) chk("drain_model_empty", 128'(0), 128'(1));
            else chk("drain_data", 128'(bus.rd_data), 128'(exp_q.pop_front()));
            bus.rd_en = 1'b1;
            tick();
        end
        bus.rd_en = 1'b0;
        chk("drain_empty", 128'(bus.rd_empty), 128'(1));
        chk("drain_model_left", 128'(exp_q.size()), 128'(0));
        chk("empty_data_zero", 128'(bus.rd_data), 128'(0));
    endtask

    initial begin
        F1 = mkf(5, 40, 80, 130, 200, 300);
        F2 = mkf(1, 2, 3, 4, 5, 6);
        F3 = mkf(511, 0, 511, 0, 511, 0);
        F4 = mkf(17, 33, 65, 129, 257, 100);
        //          req rd chg vld ack busy lvl empty
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 1};  // reset state
        tbl[1] = '{0, 0, 0, 1, 1, 1, 0, 1};  // pulse + ack 1 clock after req
        tbl[2] = '{0, 0, 1, 0, 0, 1, 0, 1};  // counter 0 -> 1 applied here
        tbl[3] = '{0, 0, 0, 0, 0, 1, 0, 1};
        tbl[4] = '{0, 0, 0, 0, 0, 1, 0, 1};
        tbl[5] = '{0, 0, 0, 0, 0, 1, 0, 1};  // CAPTURE
        tbl[6] = '{0, 1, 0, 0, 0, 0, 1, 0};  // record visible 4 clocks after change; pop it
        tbl[7] = '{0, 1, 0, 0, 0, 0, 0, 1};  // pop on empty is ignored
        tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

        // ---- table: reset, issue, capture latency, pop ----
        do_reset();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t%0d_valid", i), 128'(bus.peaks_valid), 128'(tbl[i].e_vld));
            chk($sformatf("t%0d_ack", i),   128'(bus.frame_ack),   128'(tbl[i].e_ack));
            chk($sformatf("t%0d_busy", i),  128'(bus.busy),        128'(tbl[i].e_busy));
            chk($sformatf("t%0d_level", i), 128'(bus.fifo_level),  128'(tbl[i].e_lvl));
            chk($sformatf("t%0d_empty", i), 128'(bus.rd_empty),    128'(tbl[i].e_empty));
            chk($sformatf("t%0d_data", i),  128'(bus.rd_data),
                tbl[i].e_empty ? 128'(0) : 128'(mkrec(16'd1, F1)));
            if (i == 0) begin
                chk("reset_drop", 128'(bus.drop_count), 128'(0));
                chk("reset_terr", 128'(bus.timeout_err), 128'(0));
            end
            bus.frame_req = tbl[i].req;
            bus.rd_en     = tbl[i].rd;
            if (tbl[i].chg) set_peaks(16'd1, F1);
            tick();
        end
        bus.rd_en = 1'b0;

        // ---- issue timing with frame_req held high ----
        do_reset();
        p1 = -1; p2 = -1; extra = 0; ackmis = 0;
        bus.frame_req = 1'b1;
        for (int c = 1; c <= 280; c++) begin
            tick();
            if (bus.peaks_valid) begin
                if (p1 < 0) p1 = c; else if (p2 < 0) p2 = c; else extra++;
            end
            if (bus.frame_ack !== bus.peaks_valid) ackmis++;
            if (c == 3) begin set_peaks(16'd1, F1); exp_q.push_back(mkrec(16'd1, F1)); end
            if (c == 273) bus.frame_req = 1'b0;
            if (c == 275) begin set_peaks(16'd2, F2); exp_q.push_back(mkrec(16'd2, F2)); end
        end
        chk("first_pulse_cycle", 128'(p1), 128'(1));
        chk("second_pulse_cycle", 128'(p2), 128'(1 + MIN_GAP));
        chk("extra_pulses", 128'(extra), 128'(0));
        chk("ack_with_pulse", 128'(ackmis), 128'(0));
        chk("two_records", 128'(bus.fifo_level), 128'(2));

        // ---- full FIFO drop, then recovery after one pop ----
        do_frame(16'd3, F3, 0, got);
        do_frame(16'd4, F4, 0, got);
        chk("fifo_full_level", 128'(bus.fifo_level), 128'(FIFO_DEPTH));
        request(got);
        chk("drop_no_pulse", 128'(got), 128'(0));
        chk("drop_count_1", 128'(bus.drop_count), 128'(1));
        chk("drop_level", 128'(bus.fifo_level), 128'(FIFO_DEPTH));
        chk("pop_head", 128'(bus.rd_data), 128'(exp_q.pop_front()));
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("pop_level", 128'(bus.fifo_level), 128'(FIFO_DEPTH - 1));
        do_frame(16'd5, F1, 0, got);
        chk("reissue_after_pop", 128'(got), 128'(1));
        drain();

        // ---- timeout and clear_err ----
        request(got);
        chk("to_issue", 128'(got), 128'(1));
        n = 0;
        while (n < TIMEOUT + 100 && !bus.timeout_err) begin
            tick();
            n++;
        end
        chk("timeout_err_set", 128'(bus.timeout_err), 128'(1));
        chk("timeout_cycles", 128'(n >= TIMEOUT && n <= TIMEOUT + 1), 128'(1));
        chk("timeout_idle", 128'(bus.busy), 128'(0));
        chk("timeout_level", 128'(bus.fifo_level), 128'(0));
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        chk("clear_terr", 128'(bus.timeout_err), 128'(0));
        chk("clear_drop", 128'(bus.drop_count), 128'(0));

        // ---- reset in WAIT with two records queued ----
        do_reset();
        do_frame(16'd1, F2, 0, got);
        do_frame(16'd2, F3, 0, got);
        request(got);
        repeat (5) tick();
        chk("pre_reset_level", 128'(bus.fifo_level), 128'(2));
        chk("pre_reset_busy", 128'(bus.busy), 128'(1));
        reset = 1'b1;
        #1;
        chk("async_rst_level", 128'(bus.fifo_level), 128'(0));
        chk("async_rst_valid", 128'(bus.peaks_valid), 128'(0));
        chk("async_rst_busy", 128'(bus.busy), 128'(0));
        chk("async_rst_empty", 128'(bus.rd_empty), 128'(1));
        tick();
        reset = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        set_peaks(16'd3, F4);
        repeat (10) tick();
        chk("no_push_unissued", 128'(bus.fifo_level), 128'(0));
        chk("no_busy_unissued", 128'(bus.busy), 128'(0));

        // ---- counter wrap, then push + pop in the CAPTURE cycle ----
        do_reset();
        set_peaks(16'hFFFF, F1);
        repeat (5) tick();
        do_frame(16'd0, F2, 0, got);
        chk("wrap_record", 128'(bus.rd_data), 128'(mkrec(16'd0, F2)));
        do_frame(16'd1, F3, 0, got);
        do_frame(16'd2, F4, 1, got);
        chk("simul_level", 128'(bus.fifo_level), 128'(2));
        drain();

        // ---- randomized traffic against the record-queue model ----
        do_reset();
        cur_cnt = 16'd0; last_p = -100000; pend = -1; drops = 0; prev_lvl = 0;
        for (int c = 0; c < 9300; c++) begin
            tick();
            if (pend == 0) begin
                cur_cnt = cur_cnt + 16'd1;
                rf = FW'({$urandom(), $urandom()});
                set_peaks(cur_cnt, rf);
                exp_q.push_back(mkrec(cur_cnt, rf));
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
            if (bus.peaks_valid) begin
                chk("rand_gap", 128'((c - last_p) >= MIN_GAP), 128'(1));
                last_p = c;
                pend = int'($urandom_range(2, 30));
            end
            if (bus.frame_ack) begin
                bus.frame_req = 1'b0;
                if (!bus.peaks_valid) begin
                    drops++;
                    chk("rand_drop_when_full", 128'(prev_lvl), 128'(FIFO_DEPTH));
                end
            end else if (!bus.frame_req && c < 9000 && $urandom_range(0, 3) == 0) begin
                bus.frame_req = 1'b1;
            end
            if (c >= 9000 && bus.frame_req) bus.frame_req = 1'b0;
            rd = (((c / 2000) % 2 == 1) || c >= 9000) && ($urandom_range(0, 3) == 0);
            if (rd && !bus.rd_empty) begin
                if (exp_q.size() == 0) chk("rand_model_empty", 128'(0), 128'(1));
                else chk("rand_pop_data", 128'(bus.rd_data), 128'(exp_q.pop_front()));
            end
            bus.rd_en = rd;
            prev_lvl = int'(bus.fifo_level);
        end
        bus.rd_en = 1'b0;
        drain();
        chk("rand_drop_count", 128'(bus.drop_count), 128'(drops));
        chk("rand_no_timeout", 128'(bus.timeout_err), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/peaks_frame_scheduler.md
Name: peaks_frame_scheduler

Overview:
- Sequences FFT frames into the peaks datapath.
- Issues single-cycle valid pulses to the peaks block, spaced at least MIN_GAP clocks apart, so the peaks maximum sampling rate is never exceeded.
- Detects each completed peak set and pushes a fingerprint record (time counter plus peak frequencies) into a small show-ahead FIFO that the host drains.
- Sits between the FFT frame-ready handshake and the host readout interface.

Parameters:
- PEAKS, 6, number of peak bins per frame.
- FREQ_WIDTH, 9, width of each peak frequency index.
- AMPL_WIDTH, 8, width of each final peak amplitude.
- TIME_WIDTH, 16, width of the peaks time counter.
- MIN_GAP, 272, minimum clocks between consecutive peaks_valid pulses (1..65535).
- TIMEOUT, 1024, clocks to wait for a completed peak set before aborting.
- FIFO_DEPTH, 4, number of record slots (power of 2, at least 2).

Ports:
- clk  in  1  clock.
- reset  in  1  reset (see Behaviour).
- frame_req  in  1  FFT frame available; held high until frame_ack.
- frame_ack  out  1  one-cycle acknowledge; frame consumed (issued or dropped).
- peaks_valid  out  1  one-cycle sample strobe to the peaks block.
- peaks_counter  in  TIME_WIDTH  peaks output frame counter; increments once per completed frame.
- peaks_freqs  in  PEAKS*FREQ_WIDTH  packed peak frequencies; bin 0 in the LSBs.
- peaks_ampls  in  PEAKS*AMPL_WIDTH  packed peak amplitudes; used only with the optional feature.
- rd_en  in  1  host pop.
- rd_data  out  REC_W  head record, show-ahead.
- rd_empty  out  1  FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  records held.
- drop_count  out  16  frames dropped because the FIFO was full; saturates at 65535.
- timeout_err  out  1  sticky: a frame never completed.
- clear_err  in  1  clears timeout_err and drop_count.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. All state is clocked on posedge clk.
- Reset values:
  - frame_ack=0, peaks_valid=0, busy=0.
  - rd_empty=1, fifo_level=0, rd_data=0.
  - drop_count=0, timeout_err=0, gap counter=0, state=IDLE.
- Input capture: all peaks_* inputs pass through a two-stage register, treated as asynchronous to clk. last_cnt holds the stage-2 counter value and is reloaded from it on reset release.
- REC_W = TIME_WIDTH + PEAKS*FREQ_WIDTH. Record layout: {counter, freqs}, with freqs in the LSBs.
- Gap counter:
  - Loads MIN_GAP-1 on every peaks_valid pulse.
  - Decrements to 0 and holds there.
  - "gap_ok" means the counter equals 0.
- State IDLE:
  - frame_req=1, gap_ok=1, and fifo_level < FIFO_DEPTH: next cycle pulse peaks_valid and frame_ack together, then go to WAIT.
  - frame_req=1 and FIFO full: pulse frame_ack only, increment drop_count, stay in IDLE.
  - frame_req=1 and not gap_ok: wait (no ack).
- State WAIT:
  - Each cycle, compare stage-2 counter against last_cnt.
  - If they differ: go to CAPTURE and set last_cnt to the stage-2 counter value.
  - If TIMEOUT cycles elapse without a change: set timeout_err and return to IDLE with no push.
  - frame_req is not acknowledged while in WAIT.
- State CAPTURE: push {stage-2 counter, stage-2 freqs} in one cycle, then go to IDLE.
- FIFO space: the slot is reserved at issue time, and only one frame is in flight at a time. A push therefore never overflows.
- Push and pop in the same cycle: fifo_level is unchanged.
- rd_en with rd_empty=1: ignored, no state change.
- rd_data: reflects the head record combinationally from the FIFO storage. It is 0 when empty.
- Counter wrap: the peaks counter wrapping from 2^TIME_WIDTH-1 to 0 counts as a change.
- clear_err: takes priority over a same-cycle drop increment.
- Latency:
  - frame_req to peaks_valid: 1 clock.
  - Peaks counter change to record visible on rd_data: 4 clocks (2 sync stages, 1 to CAPTURE, 1 push).

Optional Feature:
- Macro: PEAKS_FRAME_SCHEDULER_AMPL_EN.
- Defined:
  - REC_W = PEAKS*AMPL_WIDTH + TIME_WIDTH + PEAKS*FREQ_WIDTH.
  - Record layout: {ampls, counter, freqs}.
  - Amplitudes are captured through the same two-stage register.
- Undefined: peaks_ampls is ignored and no amplitude storage is built.

Test Plan:
- Issue timing: with MIN_GAP=272, hold frame_req high from cycle 0 -> peaks_valid pulses at cycle 1 and cycle 273, never closer; frame_ack coincides with each pulse.
- Capture: step peaks_counter from 0 to 1 with freqs {5,40,80,130,200,300} after the pulse -> 4 clocks later rd_empty=0 and rd_data={16'd1, those freqs}, fifo_level=1.
- Full FIFO: fill 4 records with no reads, then raise frame_req -> frame_ack with no peaks_valid and drop_count=1. One rd_en -> the next request issues normally.
- Timeout: issue a frame and hold peaks_counter constant for 1024 clocks -> timeout_err=1, state IDLE, fifo_level unchanged. Assert clear_err -> timeout_err=0.
- Reset mid-operation: assert reset during WAIT with 2 records queued -> fifo_level=0, peaks_valid=0, busy=0 immediately. After release, a counter change with no frame issued -> no push.
- Wrap and simultaneous: peaks_counter goes 65535 to 0 -> record pushed with counter 0. Asserting rd_en in the CAPTURE cycle with fifo_level=2 -> level stays 2.
